// File: rtl/matrix_mem_agent_if.sv
// Bundle of controller requests/readies, RAM port, row register file port and
// MAC array port served by matrix_mem_agent.
interface matrix_mem_agent_if #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int ACC_W = 18,
    parameter int AW    = 8
);
    localparam int LW = $clog2(N);

    logic               fetch_A;
    logic               fetch_B;
    logic               store_C;
    logic               fetch_A_ready;
    logic               fetch_B_ready;
    logic               store_C_ready;
    logic               full;
    logic               mem_rd_en;
    logic [AW-1:0]      mem_rd_addr;
    logic [DW-1:0]      mem_rd_data;
    logic               mem_wr_en;
    logic [AW-1:0]      mem_wr_addr;
    logic [ACC_W-1:0]   mem_wr_data;
    logic               row_wr_en;
    logic [LW-1:0]      row_idx;
    logic [DW-1:0]      row_data;
    logic               b_valid;
    logic [LW-1:0]      b_k;
    logic [LW-1:0]      b_j;
    logic [DW-1:0]      b_data;
    logic [N*ACC_W-1:0] c_data;

    modport slave (
        input  fetch_A, fetch_B, store_C, mem_rd_data, c_data,
        output fetch_A_ready, fetch_B_ready, store_C_ready, full,
               mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
               row_wr_en, row_idx, row_data, b_valid, b_k, b_j, b_data
    );

    modport master (
        output fetch_A, fetch_B, store_C, mem_rd_data, c_data,
        input  fetch_A_ready, fetch_B_ready, store_C_ready, full,
               mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
               row_wr_en, row_idx, row_data, b_valid, b_k, b_j, b_data
    );
endinterface

// File: rtl/matrix_mem_agent.sv
// Memory-side responder for the matmul controller: loads A rows, streams B,
// stores C rows through one shared 1-cycle-latency RAM port.
module matrix_mem_agent #(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int ACC_W  = 18,
    parameter int AW     = 8,
    parameter int A_BASE = 0,
    parameter int B_BASE = 16,
    parameter int C_BASE = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    matrix_mem_agent_if.slave bus
);
    localparam int LW = $clog2(N);
    localparam logic [LW-1:0] LAST = LW'(N - 1);

    typedef enum logic [3:0] {
        IDLE, RD_A, DRAIN_A, DONE_A, RD_B, DRAIN_B, DONE_B, WR_C, DONE_C
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [LW-1:0] r_i;
    logic [LW-1:0] r_k;
    logic [LW-1:0] r_j;
    logic          r_a_v;
    logic [LW-1:0] r_a_k;
    logic          r_b_v;
    logic [LW-1:0] r_b_k;
    logic [LW-1:0] r_b_j;

    logic          w_last_k;
    logic          w_last_j;
    logic [AW-1:0] w_a_addr;
    logic [AW-1:0] w_b_addr;
    logic [AW-1:0] w_c_addr;

    assign w_last_k = (r_k == LAST);
    assign w_last_j = (r_j == LAST);
    // Truncation to AW bits gives the mod 2^AW address wrap.
    assign w_a_addr = AW'(A_BASE + int'(r_i) * N + int'(r_k));
    assign w_b_addr = AW'(B_BASE + int'(r_k) * N + int'(r_j));
    assign w_c_addr = AW'(C_BASE + int'(r_i) * N + int'(r_j));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.store_C)      w_next = WR_C;
                else if (bus.fetch_B) w_next = RD_B;
                else if (bus.fetch_A) w_next = RD_A;
            end
            RD_A:    if (w_last_k) w_next = DRAIN_A;
            DRAIN_A: w_next = DONE_A;
            DONE_A:  if (!bus.fetch_A) w_next = IDLE;
            RD_B:    if (w_last_k && w_last_j) w_next = DRAIN_B;
            DRAIN_B: w_next = DONE_B;
            DONE_B:  if (!bus.fetch_B) w_next = IDLE;
            WR_C:    if (w_last_j) w_next = DONE_C;
            DONE_C:  if (!bus.store_C) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i <= '0;
            r_k <= '0;
            r_j <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_k <= '0;
                    r_j <= '0;
                end
                RD_A: r_k <= r_k + 1'b1;
                RD_B: begin
                    r_j <= r_j + 1'b1;
                    if (w_last_j) r_k <= r_k + 1'b1;
                end
                WR_C: r_j <= r_j + 1'b1;
                // N is a power of two, so the row counter wraps on its own.
                DONE_C: if (!bus.store_C) r_i <= r_i + 1'b1;
                default: ;
            endcase
        end
    end

    // Read data arrives one cycle after the strobe; carry valid and index along.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_v <= 1'b0;
            r_a_k <= '0;
            r_b_v <= 1'b0;
            r_b_k <= '0;
            r_b_j <= '0;
        end else begin
            r_a_v <= (r_state == RD_A);
            r_a_k <= r_k;
            r_b_v <= (r_state == RD_B);
            r_b_k <= r_k;
            r_b_j <= r_j;
        end
    end

    always_comb begin
        bus.mem_rd_en     = 1'b0;
        bus.mem_rd_addr   = '0;
        bus.mem_wr_en     = 1'b0;
        bus.mem_wr_addr   = '0;
        bus.mem_wr_data   = '0;
        bus.row_wr_en     = r_a_v;
        bus.row_idx       = '0;
        bus.row_data      = '0;
        bus.b_valid       = r_b_v;
        bus.b_k           = '0;
        bus.b_j           = '0;
        bus.b_data        = '0;
        bus.fetch_A_ready = (r_state == DONE_A);
        bus.fetch_B_ready = (r_state == DONE_B);
        bus.store_C_ready = (r_state == DONE_C);
        bus.full          = (r_state == DONE_C) && (r_i == LAST);

        case (r_state)
            RD_A: begin
                bus.mem_rd_en   = 1'b1;
                bus.mem_rd_addr = w_a_addr;
            end
            RD_B: begin
                bus.mem_rd_en   = 1'b1;
                bus.mem_rd_addr = w_b_addr;
            end
            WR_C: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_addr = w_c_addr;
                bus.mem_wr_data = bus.c_data[int'(r_j) * ACC_W +: ACC_W];
            end
            default: ;
        endcase

        if (r_a_v) begin
            bus.row_idx  = r_a_k;
            bus.row_data = bus.mem_rd_data;
        end
        if (r_b_v) begin
            bus.b_k    = r_b_k;
            bus.b_j    = r_b_j;
            bus.b_data = bus.mem_rd_data;
        end
    end
endmodule

// File: tb/tb_matrix_mem_agent.sv
// Bench for matrix_mem_agent: RAM model, cycle-offset reference model with a
// per-cycle compare, and directed scenarios with literal expectations.
module tb_matrix_mem_agent;
    localparam int N      = 4;
    localparam int DW     = 8;
    localparam int ACC_W  = 18;
    localparam int AW     = 8;
    localparam int A_BASE = 0;
    localparam int B_BASE = 16;
    localparam int C_BASE = 32;
    localparam int MSZ    = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    matrix_mem_agent_if #(.N(N), .DW(DW), .ACC_W(ACC_W), .AW(AW)) bus ();

    matrix_mem_agent #(
        .N(N), .DW(DW), .ACC_W(ACC_W), .AW(AW),
        .A_BASE(A_BASE), .B_BASE(B_BASE), .C_BASE(C_BASE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [ACC_W-1:0]   ram [0:MSZ-1];
    logic [DW-1:0]      rf  [0:N-1];
    logic [N*ACC_W-1:0] c_vec;
    assign bus.c_data = c_vec;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // RAM with 1-cycle read latency, plus the row register file sink.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_rd_addr][DW-1:0];
        if (bus.mem_wr_en) ram[bus.mem_wr_addr] = bus.mem_wr_data;
        if (bus.row_wr_en) rf[bus.row_idx] = bus.row_data;
    end

    // Reference model: current operation and cycles elapsed since the request was taken.
    int m_op = 0;
    int m_t  = 0;
    int m_i  = 0;

    function automatic int done_t(input int op);
        case (op)
            1:       return N + 2;
            2:       return N * N + 2;
            default: return N + 1;
        endcase
    endfunction

    function automatic logic req(input int op);
        case (op)
            1:       return bus.fetch_A;
            2:       return bus.fetch_B;
            default: return bus.store_C;
        endcase
    endfunction

    function automatic logic rdy(input int op);
        case (op)
            1:       return bus.fetch_A_ready;
            2:       return bus.fetch_B_ready;
            default: return bus.store_C_ready;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_op = 0; m_t = 0; m_i = 0;
        end else if (m_op == 0) begin
            if (bus.store_C)      m_op = 3;
            else if (bus.fetch_B) m_op = 2;
            else if (bus.fetch_A) m_op = 1;
            m_t = (m_op != 0) ? 1 : 0;
        end else if (m_t >= done_t(m_op) && !req(m_op)) begin
            if (m_op == 3) m_i = (m_i + 1) % N;
            m_op = 0; m_t = 0;
        end else begin
            m_t++;
        end
    end

    always @(negedge clk) begin
        logic e_rd, e_wr, e_row, e_bv, e_ra, e_rb, e_rc, e_full;
        int   e_raddr, e_waddr, e_wdata, e_ridx, e_rdata, e_bk, e_bj, e_bd;
        if (rst_n) begin
            e_rd = 0; e_wr = 0; e_row = 0; e_bv = 0;
            e_ra = 0; e_rb = 0; e_rc = 0; e_full = 0;
            e_raddr = 0; e_waddr = 0; e_wdata = 0; e_ridx = 0;
            e_rdata = 0; e_bk = 0; e_bj = 0; e_bd = 0;
            case (m_op)
                1: begin
                    if (m_t >= 1 && m_t <= N) begin
                        e_rd = 1; e_raddr = (A_BASE + m_i * N + m_t - 1) % MSZ;
                    end
                    if (m_t >= 2 && m_t <= N + 1) begin
                        e_row = 1; e_ridx = m_t - 2;
                        e_rdata = 32'(ram[(A_BASE + m_i * N + m_t - 2) % MSZ][DW-1:0]);
                    end
                    e_ra = (m_t >= N + 2);
                end
                2: begin
                    if (m_t >= 1 && m_t <= N * N) begin
                        e_rd = 1; e_raddr = (B_BASE + m_t - 1) % MSZ;
                    end
                    if (m_t >= 2 && m_t <= N * N + 1) begin
                        e_bv = 1; e_bk = (m_t - 2) / N; e_bj = (m_t - 2) % N;
                        e_bd = 32'(ram[(B_BASE + m_t - 2) % MSZ][DW-1:0]);
                    end
                    e_rb = (m_t >= N * N + 2);
                end
                3: begin
                    if (m_t >= 1 && m_t <= N) begin
                        e_wr = 1; e_waddr = (C_BASE + m_i * N + m_t - 1) % MSZ;
                        e_wdata = 32'(c_vec[(m_t - 1) * ACC_W +: ACC_W]);
                    end
                    e_rc   = (m_t >= N + 1);
                    e_full = e_rc && (m_i == N - 1);
                end
                default: ;
            endcase
            chk("mem_rd_en",     32'(bus.mem_rd_en),     32'(e_rd));
            chk("mem_rd_addr",   32'(bus.mem_rd_addr),   32'(e_raddr));
            chk("mem_wr_en",     32'(bus.mem_wr_en),     32'(e_wr));
            chk("mem_wr_addr",   32'(bus.mem_wr_addr),   32'(e_waddr));
            chk("mem_wr_data",   32'(bus.mem_wr_data),   32'(e_wdata));
            chk("row_wr_en",     32'(bus.row_wr_en),     32'(e_row));
            chk("row_idx",       32'(bus.row_idx),       32'(e_ridx));
            chk("row_data",      32'(bus.row_data),      32'(e_rdata));
            chk("b_valid",       32'(bus.b_valid),       32'(e_bv));
            chk("b_k",           32'(bus.b_k),           32'(e_bk));
            chk("b_j",           32'(bus.b_j),           32'(e_bj));
            chk("b_data",        32'(bus.b_data),        32'(e_bd));
            chk("fetch_A_ready", 32'(bus.fetch_A_ready), 32'(e_ra));
            chk("fetch_B_ready", 32'(bus.fetch_B_ready), 32'(e_rb));
            chk("store_C_ready", 32'(bus.store_C_ready), 32'(e_rc));
            chk("full",          32'(bus.full),          32'(e_full));
        end
    end

    // Event counters for the directed scenarios.
    int        cnt_rd = 0;
    int        cnt_wr = 0;
    int        cnt_bv = 0;
    logic [15:0] b_ones = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_rd_en) cnt_rd++;
            if (bus.mem_wr_en) cnt_wr++;
            if (bus.b_valid) begin
                cnt_bv++;
                if (bus.b_data != '0) b_ones[int'(bus.b_k) * N + int'(bus.b_j)] = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int op, input logic v);
        case (op)
            1:       bus.fetch_A = v;
            2:       bus.fetch_B = v;
            default: bus.store_C = v;
        endcase
    endtask

    task automatic wait_ready(input int op, output int lat, output logic full_at);
        bit seen = 0;
        lat = 0;
        full_at = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rdy(op)) begin
                seen = 1;
                full_at = bus.full;
            end
        end
        if (!seen) chk("ready_timeout", 32'(0), 32'(1));
    endtask

    task automatic run_op(input int op, input int hold, output int lat, output logic full_at);
        tick();
        set_req(op, 1'b1);
        wait_ready(op, lat, full_at);
        repeat (hold) @(negedge clk);
        @(posedge clk);
        #1;
        set_req(op, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("ready_clear", 32'(rdy(op)), 32'(0));
    endtask

    initial begin
        int   lat;
        int   rcnt;
        logic fa;
        bus.fetch_A = 1'b0;
        bus.fetch_B = 1'b0;
        bus.store_C = 1'b0;
        c_vec = {18'd40, 18'd30, 18'd20, 18'd10};
        for (int a = 0; a < MSZ; a++) ram[a] = '0;
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                ram[A_BASE + r * N + k] = ACC_W'(r * N + k + 1);
                ram[B_BASE + r * N + k] = (r == k) ? ACC_W'(1) : '0;
            end

        #1 rst_n = 1'b0;
        #2;
        chk("rst_rd_en",   32'(bus.mem_rd_en),  32'(0));
        chk("rst_wr_en",   32'(bus.mem_wr_en),  32'(0));
        chk("rst_readies", 32'({bus.fetch_A_ready, bus.fetch_B_ready, bus.store_C_ready, bus.full}), 32'(0));
        chk("rst_valids",  32'({bus.row_wr_en, bus.b_valid}), 32'(0));
        #14 rst_n = 1'b1;

        // Row 0 of A loaded into the row register file.
        run_op(1, 3, lat, fa);
        chk("A_latency", 32'(lat), 32'(6));
        for (int k = 0; k < N; k++) chk("A_row0", 32'(rf[k]), 32'(k + 1));

        // Identity B streamed.
        cnt_bv = 0; b_ones = '0;
        run_op(2, 1, lat, fa);
        chk("B_latency", 32'(lat), 32'(18));
        chk("B_beats",   32'(cnt_bv), 32'(16));
        chk("B_diag",    32'(b_ones), 32'(16'h8421));

        // Four full row sequences; full only on the last row.
        for (int r = 0; r < N; r++) begin
            run_op(1, 0, lat, fa);
            run_op(2, 0, lat, fa);
            run_op(3, 2, lat, fa);
            chk("C_latency", 32'(lat), 32'(5));
            chk("C_full",    32'(fa), 32'(r == N - 1));
        end
        for (int j = 0; j < N; j++) begin
            chk("C_row0_mem", 32'(ram[C_BASE + j]), 32'((j + 1) * 10));
            chk("C_row3_mem", 32'(ram[C_BASE + 12 + j]), 32'((j + 1) * 10));
        end

        // All three requests together: store wins, no reads issued.
        tick();
        cnt_rd = 0; cnt_wr = 0;
        bus.fetch_A = 1'b1; bus.fetch_B = 1'b1; bus.store_C = 1'b1;
        wait_ready(3, lat, fa);
        chk("prio_latency", 32'(lat), 32'(5));
        chk("prio_reads",   32'(cnt_rd), 32'(0));
        chk("prio_writes",  32'(cnt_wr), 32'(4));
        @(posedge clk);
        #1;
        bus.fetch_A = 1'b0; bus.fetch_B = 1'b0; bus.store_C = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("prio_idle", 32'({bus.store_C_ready, bus.mem_rd_en, bus.mem_wr_en}), 32'(0));

        // fetch_A dropped at cycle 2 (row counter now 1).
        tick();
        bus.fetch_A = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 bus.fetch_A = 1'b0;
        rcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.fetch_A_ready) rcnt++;
        end
        chk("drop_ready_cycles", 32'(rcnt), 32'(1));
        chk("drop_row1_k0", 32'(rf[0]), 32'(5));
        chk("drop_row1_k3", 32'(rf[3]), 32'(8));

        // Reset during cycle 8 of the B stream.
        tick();
        bus.fetch_B = 1'b1;
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rd",     32'({bus.mem_rd_en, bus.mem_rd_addr}), 32'(0));
        chk("arst_b",      32'({bus.b_valid, bus.b_k, bus.b_j, bus.b_data}), 32'(0));
        chk("arst_other",  32'({bus.mem_wr_en, bus.row_wr_en, bus.fetch_B_ready, bus.full}), 32'(0));
        bus.fetch_B = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.fetch_A = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_rd_en",   32'(bus.mem_rd_en),   32'(1));
        chk("post_rst_rd_addr", 32'(bus.mem_rd_addr), 32'(A_BASE));
        wait_ready(1, lat, fa);
        chk("post_rst_latency", 32'(lat), 32'(5));
        @(posedge clk);
        #1 bus.fetch_A = 1'b0;
        repeat (2) @(posedge clk);
        chk("post_rst_row0", 32'(rf[1]), 32'(2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
